// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational RV32/RV64 immediate decode
// feeding a DEPTH-entry result FIFO with a saturating unrecognised-opcode counter.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = XLEN + 3 + 1 + TAG_W;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6
    } fmt_e;

    logic [6:0]      opc;
    logic [2:0]      funct3;
    logic            sh_f3;
    logic [63:0]     imm64;
    fmt_e            dec_fmt;
    logic            dec_err;

    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   count;
    logic            full;
    logic            push;
    logic            pop;

    // Immediates are built at 64 bits and truncated, so sign extension to
    // XLEN = 32 falls out of the same expressions.
    always_comb begin
        opc     = in_instr[6:0];
        funct3  = in_instr[14:12];
        sh_f3   = (funct3 == 3'b001) || (funct3 == 3'b101);
        imm64   = '0;
        dec_fmt = FMT_NONE;
        dec_err = 1'b0;
        case (opc)
            7'b0000011, 7'b1100111: begin
                dec_fmt = FMT_I;
                imm64   = {{52{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0010011: begin
                if (sh_f3) begin
                    dec_fmt     = FMT_SH;
                    imm64[4:0]  = in_instr[24:20];
                    if (XLEN == 64) imm64[5] = in_instr[25];
                end else begin
                    dec_fmt = FMT_I;
                    imm64   = {{52{in_instr[31]}}, in_instr[31:20]};
                end
            end
            7'b0011011: begin
                if (XLEN != 64) begin
                    dec_err = 1'b1;
                end else if (sh_f3) begin
                    dec_fmt    = FMT_SH;
                    imm64[4:0] = in_instr[24:20];
                end else begin
                    dec_fmt = FMT_I;
                    imm64   = {{52{in_instr[31]}}, in_instr[31:20]};
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                imm64   = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                imm64   = {{52{in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                imm64   = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                imm64   = {{44{in_instr[31]}}, in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            end
            default: dec_err = 1'b1;
        endcase
    end

    assign full      = (count == PW'(DEPTH));
    assign in_ready  = !rst && !full;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign {out_imm, out_fmt, out_err, out_tag} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {imm64[XLEN-1:0], dec_fmt, dec_err, in_tag};
                wr_ptr              <= wr_ptr + PW'(1);
                if (dec_err && (err_count != '1)) err_count <= err_count + 16'd1;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: three instances (XLEN/DEPTH variants),
// table vectors, directed corner sequences and a queue-based reference model.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        err;
        logic [7:0]  tag;
    } exp_t;

    typedef struct {
        int          sel;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        err;
    } vec_t;

    localparam logic [6:0] OPCS [10] = '{7'h03, 7'h67, 7'h13, 7'h13, 7'h1B,
                                         7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    logic        clk;
    logic        rst;
    logic        fl    [3];
    logic        iv    [3];
    logic [31:0] ins   [3];
    logic [7:0]  tg    [3];
    logic        ordy  [3];
    logic        irdy  [3];
    logic        ovld  [3];
    logic [63:0] oimm  [3];
    logic [2:0]  ofmt  [3];
    logic        oerr  [3];
    logic [7:0]  otag  [3];
    logic [15:0] ecnt  [3];
    logic [63:0] oimm64_a;
    logic [31:0] oimm32;
    logic [63:0] oimm64_b;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    exp_t        sbq   [3][$];
    int          ec_m  [3];
    vec_t        vt    [$];

    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(8)) dut (
        .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
        .in_instr(ins[0]), .in_tag(tg[0]), .out_valid(ovld[0]), .out_ready(ordy[0]),
        .out_imm(oimm64_a), .out_fmt(ofmt[0]), .out_err(oerr[0]), .out_tag(otag[0]),
        .err_count(ecnt[0]));

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(8)) dut32 (
        .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
        .in_instr(ins[1]), .in_tag(tg[1]), .out_valid(ovld[1]), .out_ready(ordy[1]),
        .out_imm(oimm32), .out_fmt(ofmt[1]), .out_err(oerr[1]), .out_tag(otag[1]),
        .err_count(ecnt[1]));

    imm_gen_pipe #(.XLEN(64), .DEPTH(4), .TAG_W(8)) dut4 (
        .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
        .in_instr(ins[2]), .in_tag(tg[2]), .out_valid(ovld[2]), .out_ready(ordy[2]),
        .out_imm(oimm64_b), .out_fmt(ofmt[2]), .out_err(oerr[2]), .out_tag(otag[2]),
        .err_count(ecnt[2]));

    assign oimm[0] = oimm64_a;
    assign oimm[1] = {32'h0, oimm32};
    assign oimm[2] = oimm64_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int xlen_of(int i);
        return (i == 1) ? 32 : 64;
    endfunction

    function automatic int depth_of(int i);
        return (i == 2) ? 4 : 2;
    endfunction

    // Field values assembled arithmetically, then two's-complement folded.
    function automatic exp_t ref_dec(int xlen, logic [31:0] w);
        exp_t   e;
        longint v;
        int     wid;
        bit     sx;
        int     opc;
        int     f3;
        opc   = int'(w[6:0]);
        f3    = int'(w[14:12]);
        e.fmt = 3'd0;
        e.err = 1'b0;
        e.tag = 8'd0;
        v     = 0;
        wid   = 1;
        sx    = 1'b0;
        case (opc)
            'h03, 'h67: begin e.fmt = 3'd1; v = longint'(w[31:20]); wid = 12; sx = 1'b1; end
            'h13, 'h1B: begin
                if (opc == 'h1B && xlen == 32) e.err = 1'b1;
                else if (f3 == 1 || f3 == 5) begin
                    e.fmt = 3'd6;
                    v = longint'(w[25:20]) % ((xlen == 64 && opc == 'h13) ? 64 : 32);
                end else begin
                    e.fmt = 3'd1; v = longint'(w[31:20]); wid = 12; sx = 1'b1;
                end
            end
            'h23: begin
                e.fmt = 3'd2; v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
                wid = 12; sx = 1'b1;
            end
            'h63: begin
                e.fmt = 3'd3;
                v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                wid = 13; sx = 1'b1;
            end
            'h37, 'h17: begin e.fmt = 3'd4; v = longint'(w[31:12]) * 4096; wid = 32; sx = 1'b1; end
            'h6F: begin
                e.fmt = 3'd5;
                v = longint'(w[31]) * (longint'(1) << 20) + longint'(w[19:12]) * 4096
                  + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                wid = 21; sx = 1'b1;
            end
            default: e.err = 1'b1;
        endcase
        if (sx && v >= (longint'(1) << (wid - 1))) v = v - (longint'(1) << wid);
        e.imm = (xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 12);
        if (k < 10) w[6:0] = OPCS[k];
        return w;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int i, logic [31:0] w, logic [7:0] t);
        bit ok;
        ok    = 1'b0;
        iv[i] = 1'b1;
        ins[i] = w;
        tg[i] = t;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = irdy[i];
            tick();
        end
        iv[i] = 1'b0;
        chk($sformatf("u%0d_push_accept", i), 64'(ok), 64'd1);
    endtask

    task automatic chk_reset_outputs(int i);
        chk($sformatf("u%0d_rst_valid", i), 64'(ovld[i]), 64'd0);
        chk($sformatf("u%0d_rst_imm", i), oimm[i], 64'd0);
        chk($sformatf("u%0d_rst_fmt", i), 64'(ofmt[i]), 64'd0);
        chk($sformatf("u%0d_rst_err", i), 64'(oerr[i]), 64'd0);
        chk($sformatf("u%0d_rst_tag", i), 64'(otag[i]), 64'd0);
        chk($sformatf("u%0d_rst_errcnt", i), 64'(ecnt[i]), 64'd0);
    endtask

    // Scoreboard: check the head against the model, then advance the model
    // by what the upcoming edge will do.
    exp_t mon_e;
    bit   mon_rdy;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                chk($sformatf("u%0d_ready_in_rst", i), 64'(irdy[i]), 64'd0);
                sbq[i].delete();
                ec_m[i] = 0;
            end else begin
                mon_rdy = (sbq[i].size() < depth_of(i));
                chk($sformatf("u%0d_in_ready", i), 64'(irdy[i]), 64'(mon_rdy));
                chk($sformatf("u%0d_out_valid", i), 64'(ovld[i]), 64'(sbq[i].size() > 0));
                chk($sformatf("u%0d_err_count", i), 64'(ecnt[i]), 64'(ec_m[i]));
                if (sbq[i].size() > 0) begin
                    chk($sformatf("u%0d_head_imm", i), oimm[i], sbq[i][0].imm);
                    chk($sformatf("u%0d_head_fmt", i), 64'(ofmt[i]), 64'(sbq[i][0].fmt));
                    chk($sformatf("u%0d_head_err", i), 64'(oerr[i]), 64'(sbq[i][0].err));
                    chk($sformatf("u%0d_head_tag", i), 64'(otag[i]), 64'(sbq[i][0].tag));
                end
                if (fl[i]) begin
                    sbq[i].delete();
                end else begin
                    if (sbq[i].size() > 0 && ordy[i]) void'(sbq[i].pop_front());
                    if (iv[i] && mon_rdy) begin
                        mon_e     = ref_dec(xlen_of(i), ins[i]);
                        mon_e.tag = tg[i];
                        sbq[i].push_back(mon_e);
                        if (mon_e.err && ec_m[i] != 'hFFFF) ec_m[i]++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fl[i] = 1'b0; iv[i] = 1'b0; ins[i] = '0; tg[i] = '0; ordy[i] = 1'b1;
            ec_m[i] = 0;
        end

        // Reset state
        tick();
        tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset_outputs(i);
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("u%0d_ready_after_rst", i), 64'(irdy[i]), 64'd1);
        tick();

        // Format decode vectors
        vt.push_back('{0, 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0});
        vt.push_back('{0, 32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0});
        vt.push_back('{0, 32'h80000037, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0});
        vt.push_back('{0, 32'h0080006F, 64'h8,                   3'd5, 1'b0});
        vt.push_back('{0, 32'h00112423, 64'h8,                   3'd2, 1'b0});
        vt.push_back('{0, 32'h03F09093, 64'd63,                  3'd6, 1'b0});
        vt.push_back('{0, 32'h43F0D093, 64'd63,                  3'd6, 1'b0});
        vt.push_back('{0, 32'h43F0D09B, 64'd31,                  3'd6, 1'b0});
        vt.push_back('{0, 32'h0000001B, 64'h0,                   3'd1, 1'b0});
        vt.push_back('{0, 32'hFFF0C093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0});
        vt.push_back('{0, 32'h0000007F, 64'h0,                   3'd0, 1'b1});
        vt.push_back('{1, 32'h01F09093, 64'd31,                  3'd6, 1'b0});
        vt.push_back('{1, 32'h43F0D093, 64'd31,                  3'd6, 1'b0});
        vt.push_back('{1, 32'h0000001B, 64'h0,                   3'd0, 1'b1});
        vt.push_back('{1, 32'hFFF00093, 64'h0000_0000_FFFF_FFFF, 3'd1, 1'b0});
        vt.push_back('{2, 32'h80000017, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0});
        foreach (vt[k]) begin
            push(vt[k].sel, vt[k].instr, 8'(k));
            @(negedge clk);
            chk($sformatf("vec%0d_valid", k), 64'(ovld[vt[k].sel]), 64'd1);
            chk($sformatf("vec%0d_imm", k), oimm[vt[k].sel], vt[k].imm);
            chk($sformatf("vec%0d_fmt", k), 64'(ofmt[vt[k].sel]), 64'(vt[k].fmt));
            chk($sformatf("vec%0d_err", k), 64'(oerr[vt[k].sel]), 64'(vt[k].err));
            chk($sformatf("vec%0d_tag", k), 64'(otag[vt[k].sel]), 64'(k));
            tick();
        end

        // Backpressure on the DEPTH=2 instance
        ordy[0] = 1'b0;
        push(0, 32'h00000093, 8'd0);
        push(0, 32'h00100093, 8'd1);
        iv[0] = 1'b1; ins[0] = 32'h00200093; tg[0] = 8'd2;
        repeat (3) begin
            @(negedge clk);
            chk("bp_full_ready", 64'(irdy[0]), 64'd0);
            chk("bp_stall_tag", 64'(otag[0]), 64'd0);
            chk("bp_stall_imm", oimm[0], 64'd0);
            tick();
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp_pop_ready", 64'(irdy[0]), 64'd0);
        chk("bp_order0", 64'(otag[0]), 64'd0);
        tick();
        @(negedge clk);
        chk("bp_reopen_ready", 64'(irdy[0]), 64'd1);
        chk("bp_order1", 64'(otag[0]), 64'd1);
        tick();
        iv[0] = 1'b0;
        @(negedge clk);
        chk("bp_order2", 64'(otag[0]), 64'd2);
        chk("bp_imm2", oimm[0], 64'd2);
        tick();
        @(negedge clk);
        chk("bp_drained", 64'(ovld[0]), 64'd0);
        tick();

        // Mid-stream reset with two entries buffered
        ordy[0] = 1'b0;
        push(0, 32'h00000013, 8'd10);
        push(0, 32'h0000007F, 8'd11);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_ready_low", 64'(irdy[0]), 64'd0);
        tick();
        rst = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk_reset_outputs(0);
        chk("mrst_ready_high", 64'(irdy[0]), 64'd1);
        tick();

        // Unrecognised opcode counting and saturation
        for (int k = 0; k < 3; k++) push(0, 32'h0000007F, 8'(20 + k));
        @(negedge clk);
        chk("err_count_3", 64'(ecnt[0]), 64'd3);
        tick();
        iv[0] = 1'b1; ins[0] = 32'h0000007F; tg[0] = 8'h5A;
        repeat (65540) tick();
        iv[0] = 1'b0;
        @(negedge clk);
        chk("err_count_sat", 64'(ecnt[0]), 64'hFFFF);
        tick();
        push(0, 32'h0000007F, 8'd7);
        @(negedge clk);
        chk("err_count_hold", 64'(ecnt[0]), 64'hFFFF);
        chk("err_after_sat_fmt", 64'(ofmt[0]), 64'd0);
        tick();

        // Flush with a simultaneous push on the DEPTH=4 instance
        ordy[2] = 1'b0;
        push(2, 32'h00000013, 8'd1);
        push(2, 32'h00112423, 8'd2);
        push(2, 32'hFFF00093, 8'd3);
        iv[2] = 1'b1; ins[2] = 32'h0000007F; tg[2] = 8'd4; fl[2] = 1'b1;
        @(negedge clk);
        tick();
        iv[2] = 1'b0; fl[2] = 1'b0;
        @(negedge clk);
        chk("flush_valid", 64'(ovld[2]), 64'd0);
        chk("flush_ready", 64'(irdy[2]), 64'd1);
        chk("flush_errcnt", 64'(ecnt[2]), 64'd0);
        tick();
        ordy[2] = 1'b1;
        push(2, 32'h0080006F, 8'd5);
        @(negedge clk);
        chk("post_flush_tag", 64'(otag[2]), 64'd5);
        chk("post_flush_imm", oimm[2], 64'd8);
        tick();

        // Random traffic on all instances against the reference model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                iv[i]   = ($urandom % 4) != 0;
                ins[i]  = rand_instr();
                tg[i]   = 8'($urandom);
                ordy[i] = ($urandom % 3) != 0;
                fl[i]   = ($urandom % 40) == 0;
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b1;
        end
        repeat (6) tick();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
